// File: rtl/serial_pkg.sv
// Shared types and the hex-to-7-segment table for the serial transmitter
// and the board-level display logic.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } tx_state_t;

    // Segment order {dp, g, f, e, d, c, b, a}, active high, dp always off.
    localparam logic [7:0] SEG_TABLE [16] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F,
        8'h66, 8'h6D, 8'h7D, 8'h07,
        8'h7F, 8'h6F, 8'h77, 8'h7C,
        8'h39, 8'h5E, 8'h79, 8'h71
    };

    function automatic logic [7:0] hex_to_seg(input logic [3:0] hex);
        return SEG_TABLE[hex];
    endfunction

endpackage

// File: rtl/hex7seg.sv
// Combinational hex digit to 7-segment decoder, shared with the board top.
module hex7seg
    import serial_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [7:0] seg_o
);

    always_comb begin
        seg_o = hex_to_seg(hex_i);
    end

endmodule

// File: rtl/serial_tx.sv
// Parallel-in, serial-out transmitter: LSB first, BIT_CYCLES clocks per bit,
// with a strobe in the last cycle of each bit for the receiving shift register.
module serial_tx
    import serial_pkg::*;
#(
    parameter int NBITS_DATA = 4,
    parameter int BIT_CYCLES = 1
) (
    input  logic                  clk_2,
    input  logic                  reset,
    input  logic                  start,
    input  logic [NBITS_DATA-1:0] paralelo,
    output logic                  ready,
    output logic                  serial,
    output logic                  shift_en,
    output logic                  done,
    output logic [NBITS_DATA-1:0] shadow,
    output logic [7:0]            SEG
);

    localparam int BW = $clog2(NBITS_DATA + 1);
    localparam int CW = $clog2(BIT_CYCLES + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(NBITS_DATA - 1);
    localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);

    tx_state_t               state_q,   state_d;
    logic [NBITS_DATA-1:0]   shreg_q,   shreg_d;
    logic [NBITS_DATA-1:0]   word_q,    word_d;
    logic [BW-1:0]           bit_cnt_q, bit_cnt_d;
    logic [CW-1:0]           cyc_cnt_q, cyc_cnt_d;
    logic                    bit_end;
    logic [3:0]              seg_nibble;

    // Last cycle of the current bit period; only meaningful while shifting.
    assign bit_end = (state_q == SHIFT) && (cyc_cnt_q == CYC_LAST);

    always_ff @(posedge clk_2) begin
        if (reset) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            word_q    <= '0;
            bit_cnt_q <= '0;
            cyc_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            word_q    <= word_d;
            bit_cnt_q <= bit_cnt_d;
            cyc_cnt_q <= cyc_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        word_d    = word_q;
        bit_cnt_d = bit_cnt_q;
        cyc_cnt_d = cyc_cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    shreg_d   = paralelo;
                    word_d    = paralelo;
                    bit_cnt_d = '0;
                    cyc_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_end) begin
                    shreg_d   = shreg_q >> 1;
                    cyc_cnt_d = '0;
                    bit_cnt_d = bit_cnt_q + BW'(1);
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = DONE;
                    end
                end else begin
                    cyc_cnt_d = cyc_cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        ready    = (state_q == IDLE);
        serial   = (state_q == SHIFT) ? shreg_q[0] : 1'b0;
        shift_en = bit_end;
        done     = (state_q == DONE);
        shadow   = shreg_q;
    end

    // Narrow words are zero-extended; wide words show only their low digit.
    generate
        if (NBITS_DATA >= 4) begin : g_nib_wide
            assign seg_nibble = word_q[3:0];
        end else begin : g_nib_narrow
            assign seg_nibble = {{(4 - NBITS_DATA){1'b0}}, word_q};
        end
    endgenerate

    hex7seg u_hex7seg (
        .hex_i (seg_nibble),
        .seg_o (SEG)
    );

endmodule

// File: doc/serial_tx.md
# serial_tx

Parallel-in, serial-out transmitter: captures an `NBITS_DATA`-bit word on a start request and shifts it out LSB first, one bit per `BIT_CYCLES` clocks, with a per-bit strobe. It is the sending end for the board's serial-in shift register. Wiring `serial` to that register's serial input and `shift_en` to its shift-select reassembles the word there. It sits in `top` under switch control and drives LEDs plus a 7-segment display of the word in flight.

## Interface
Parameters:
- `NBITS_DATA`, default 4: word width. Legal range 1..16.
- `BIT_CYCLES`, default 1: clocks each bit is held on `serial`. Legal range ≥ 1.

Ports:
- `clk_2`  in  1: the only clock; all state updates on its rising edge.
- `reset`  in  1: synchronous, active-high. Sampled only on rising `clk_2`.
- `start`  in  1: transmit request. Accepted only when `start && ready` at a rising edge.
- `paralelo`  in  NBITS_DATA: word to send. Captured on the accepting edge.
- `ready`  out  1: high only in state IDLE.
- `serial`  out  1: current data bit. 0 when not in SHIFT.
- `shift_en`  out  1: strobe, high in the last cycle of each bit period.
- `done`  out  1: one-cycle pulse after the final bit.
- `shadow`  out  NBITS_DATA: shift register contents, for LEDs.
- `SEG`  out  8: 7-segment pattern of the captured word.

## Operation
- States: IDLE, SHIFT, DONE.
- Internal registers:
  - `shreg` [NBITS_DATA]
  - `word_q` [NBITS_DATA]
  - `bit_cnt` [$clog2(NBITS_DATA+1)]
  - `cyc_cnt` [$clog2(BIT_CYCLES+1)]
- Reset, at the edge where `reset`=1: state=IDLE, `shreg`=0, `word_q`=0, counters=0. Outputs: `ready`=1, `serial`=0, `shift_en`=0, `done`=0, `shadow`=0, `SEG`=8'h3F. Reset takes priority over every other event.
- IDLE:
  - If `start` is high: `shreg`←`paralelo`, `word_q`←`paralelo`, counters←0, go to SHIFT.
  - Otherwise hold.
- SHIFT:
  - `serial`=`shreg[0]`. `cyc_cnt` increments each cycle.
  - When `cyc_cnt`==BIT_CYCLES-1, `shift_en`=1. At that edge: `shreg`←{1'b0, `shreg`[N-1:1]}, `cyc_cnt`←0, `bit_cnt`++.
  - If that edge ends bit NBITS_DATA-1, go to DONE.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- `start` in SHIFT or DONE is ignored. It is not queued.
- `paralelo` changes outside the accepting edge have no effect.
- `word_q` holds until the next accept. `SEG` decodes `word_q` with the hex table: 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07, 8→7F, 9→6F, A→77, B→7C, C→39, D→5E, E→79, F→71.
- When NBITS_DATA>4, `SEG` shows `word_q[3:0]`.

## Timing
- Cycle 0 is the cycle whose ending edge accepts `start`. With N=NBITS_DATA and B=BIT_CYCLES:
  - Cycles 1..N·B: SHIFT. Bit i is on `serial` during cycles i·B+1..(i+1)·B.
  - `shift_en` is high on cycles B, 2B, …, N·B.
  - Cycle N·B+1: DONE, `done`=1, `ready`=0.
  - Cycle N·B+2: IDLE, `ready`=1. With `start` held high, the next accept happens at the end of this cycle.
- Frame period is N·B+2 cycles. For N=4, B=1 that is 6.
- Every output is decoded from registered state only. There is no combinational path from any input to any output.
- Reset mid-frame: the frame is aborted at that edge. `done` never pulses for the aborted frame.

## Structure
- Package `serial_pkg`: `typedef enum logic [1:0] {IDLE, SHIFT, DONE} tx_state_t`, and the 16-entry hex→7-segment constant array.
- Sub-module `hex7seg` (4-bit in, 8-bit out): combinational decode from the package table. Shared with `top`'s existing display logic.
- `serial_tx` holds the FSM, counters and shift register.

## Test plan
- Reset held for 2 cycles, then released with `start`=0 → `ready`=1, `serial`=0, `shift_en`=0, `done`=0, `shadow`=0, `SEG`=8'h3F, stable for 10 cycles.
- B=1, `paralelo`=4'b1011, one-cycle `start`:
  - `serial`=1,1,0,1 on cycles 1–4, `shift_en` high on cycles 1–4, `done` on cycle 5, `ready` on cycle 6, `SEG`=8'h7C.
  - Looped into the 4-bit serial-in register, that register reads 4'b1011.
- B=3, `paralelo`=4'b0110 → `serial` 0,0,0,1,1,1,1,1,1,0,0,0 over cycles 1–12, `shift_en` on cycles 3, 6, 9 and 12, `done` on cycle 13.
- `start` held high, `paralelo` changing every cycle → a frame accepted every 6 cycles (B=1). Each frame carries the value present on its accepting edge.
- Reset asserted during cycle 2 of a frame → the next cycle shows `ready`=1, `serial`=0, `SEG`=8'h3F, with no `done` pulse.
- `start` pulse during cycle 3 of a frame → ignored. The frame completes unchanged and `ready` returns on cycle 6.
